program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter HALF_WORD, default 16, instruction width in bits.
REQ-002 SHALL have parameter WORD, default 32, address width in bits.
REQ-003 SHALL have parameter PROG_DEPTH, default 256, maximum program length in halfwords.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address written by the first halfword.
REQ-005 SHALL have parameter RELEASE_DELAY, default 4, cycles from last write to CPU reset release (range 1..255).
REQ-006 SHALL have port clk_i  input  1  sole clock; all state changes on the rising edge.
REQ-007 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start_i  input  1  single-cycle request to begin a program load.
REQ-009 SHALL have port prog_len_i  input  16  number of halfwords to load; sampled when start_i is accepted.
REQ-010 SHALL have port data_valid_i  input  1  source presents a halfword on data_i.
REQ-011 SHALL have port data_i  input  HALF_WORD  instruction halfword from the source.
REQ-012 SHALL have port data_ready_o  output  1  loader accepts data_i this cycle.
REQ-013 SHALL have port program_mem_write_en_o  output  1  instruction-memory write strobe.
REQ-014 SHALL have port instruction_o  output  HALF_WORD  halfword to write.
REQ-015 SHALL have port instruction_addr_o  output  WORD  byte address of the write.
REQ-016 SHALL have port cpu_reset_o  output  1  active-high synchronous reset to the CPU core.
REQ-017 SHALL have port busy_o  output  1  load or release delay in progress.
REQ-018 SHALL have port done_o  output  1  program loaded and CPU running.
REQ-019 SHALL have port error_o  output  1  last start request rejected.

Function
REQ-020 SHALL implement the states IDLE, LOAD, DRAIN and RUN.
REQ-021 IDLE SHALL drive cpu_reset_o=1, busy_o=0 and done_o=0.
REQ-022 In IDLE or RUN, start_i with 1<=prog_len_i<=PROG_DEPTH SHALL latch prog_len_i, clear the beat counter and error_o, and enter LOAD on the next edge.
REQ-023 On entering LOAD from RUN, cpu_reset_o SHALL rise and done_o SHALL fall in the same edge.
REQ-024 In IDLE or RUN, start_i with prog_len_i=0 or prog_len_i>PROG_DEPTH SHALL set error_o (sticky) and go to or stay in IDLE.
REQ-025 While in LOAD or DRAIN, start_i SHALL be ignored.
REQ-026 data_ready_o SHALL be 1 only in LOAD while count<prog_len; it SHALL be a pure function of state and count, independent of data_valid_i.
REQ-027 A beat is accepted when data_valid_i and data_ready_o are both 1 at a rising edge.
REQ-028 On acceptance, the next cycle SHALL drive program_mem_write_en_o=1, instruction_o=data_i and instruction_addr_o=BASE_ADDR+2*count, and count SHALL increment (one-cycle registered latency).
REQ-029 program_mem_write_en_o SHALL be 0 in every cycle not following an acceptance.
REQ-030 Back-to-back acceptances SHALL sustain one write per cycle.
REQ-031 Address arithmetic SHALL be WORD bits wide and wrap modulo 2^WORD.
REQ-032 When the accepted beat makes count equal prog_len, the state SHALL move to DRAIN at that edge, with the final write strobe issued in the first DRAIN cycle.
REQ-033 DRAIN SHALL keep cpu_reset_o=1 and busy_o=1 for exactly RELEASE_DELAY cycles, then enter RUN.
REQ-034 RUN SHALL drive cpu_reset_o=0, done_o=1 and busy_o=0.
REQ-035 busy_o SHALL be 1 in LOAD and DRAIN only.
REQ-036 A source stall (data_valid_i=0) in LOAD SHALL hold all state; no timeout applies.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 Asserting reset_n_i low SHALL at once force state IDLE, count 0, cpu_reset_o=1, program_mem_write_en_o=0, data_ready_o=0, busy_o=0, done_o=0, error_o=0, instruction_o=0 and instruction_addr_o=0.
REQ-039 A reset asserted mid-LOAD or mid-DRAIN SHALL abandon the load and issue no further write.
REQ-040 After reset_n_i deasserts, the block SHALL stay in IDLE until a valid start_i.

Verification
REQ-041 prog_len_i=3, data_valid_i held high, data 0xA001/0xA002/0xA003 -> writes on three consecutive cycles at addresses 0x0/0x2/0x4; cpu_reset_o falls 4 cycles after the last write; done_o=1.
REQ-042 prog_len_i=4 with data_valid_i low every other cycle -> exactly 4 strobes, addresses contiguous, no duplicate or skipped beat.
REQ-043 start_i with prog_len_i=0, then with prog_len_i=257 -> error_o=1, state IDLE, no strobe; a following start_i with prog_len_i=1 clears error_o.
REQ-044 start_i while in RUN with prog_len_i=2 -> cpu_reset_o=1 and done_o=0 on the next edge; reload completes and the CPU is released again.
REQ-045 reset_n_i pulsed low after 2 of 5 beats -> outputs immediately at reset values, data_ready_o=0, no further strobe.
REQ-046 start_i pulsed during LOAD and during DRAIN -> ignored; prog_len, count and timing unchanged.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: accepts a stream of instruction halfwords from a source,
// writes them into instruction memory at consecutive byte addresses, then
// holds the CPU in reset for a fixed settling delay before releasing it.
module program_loader #(
   parameter int              HALF_WORD     = 16,
   parameter int              WORD          = 32,
   parameter int              PROG_DEPTH    = 256,
   parameter logic [WORD-1:0] BASE_ADDR     = '0,
   parameter int              RELEASE_DELAY = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 start_i,
   input  logic [15:0]          prog_len_i,
   input  logic                 data_valid_i,
   input  logic [HALF_WORD-1:0] data_i,
   output logic                 data_ready_o,
   output logic                 program_mem_write_en_o,
   output logic [HALF_WORD-1:0] instruction_o,
   output logic [WORD-1:0]      instruction_addr_o,
   output logic                 cpu_reset_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;

   localparam logic [31:0] LP_DEPTH      = 32'(PROG_DEPTH);
   localparam logic [7:0]  LP_DELAY_LOAD = 8'(RELEASE_DELAY - 1);

   state_t           r_state;
   logic [15:0]      r_len;
   logic [15:0]      r_count;
   logic [7:0]       r_delay;

   logic             w_accept;
   logic             w_len_ok;
   logic [15:0]      w_count_next;
   logic [WORD-1:0]  w_addr;

   // A beat moves when the source offers data while we advertise readiness;
   // readiness itself is a registered function of state and count only.
   assign w_accept     = (r_state == LOAD) && data_ready_o && data_valid_i;
   assign w_len_ok     = (prog_len_i != 16'd0) && ({16'd0, prog_len_i} <= LP_DEPTH);
   assign w_count_next = r_count + 16'd1;
   assign w_addr       = BASE_ADDR + (WORD'(r_count) << 1);

   // Load sequencer: state, beat counter, release delay and every output register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state                <= IDLE;
         r_len                  <= '0;
         r_count                <= '0;
         r_delay                <= '0;
         data_ready_o           <= 1'b0;
         program_mem_write_en_o <= 1'b0;
         instruction_o          <= '0;
         instruction_addr_o     <= '0;
         cpu_reset_o            <= 1'b1;
         busy_o                 <= 1'b0;
         done_o                 <= 1'b0;
         error_o                <= 1'b0;
      end else begin
         program_mem_write_en_o <= 1'b0;
         case (r_state)
            IDLE, RUN: begin
               if (start_i) begin
                  if (w_len_ok) begin
                     r_state      <= LOAD;
                     r_len        <= prog_len_i;
                     r_count      <= '0;
                     error_o      <= 1'b0;
                     data_ready_o <= 1'b1;
                     busy_o       <= 1'b1;
                     cpu_reset_o  <= 1'b1;
                     done_o       <= 1'b0;
                  end else begin
                     r_state     <= IDLE;
                     error_o     <= 1'b1;
                     busy_o      <= 1'b0;
                     cpu_reset_o <= 1'b1;
                     done_o      <= 1'b0;
                  end
               end
            end
            LOAD: begin
               if (w_accept) begin
                  program_mem_write_en_o <= 1'b1;
                  instruction_o          <= data_i;
                  instruction_addr_o     <= w_addr;
                  r_count                <= w_count_next;
                  if (w_count_next == r_len) begin
                     r_state      <= DRAIN;
                     data_ready_o <= 1'b0;
                     r_delay      <= LP_DELAY_LOAD;
                  end
               end
            end
            DRAIN: begin
               if (r_delay == 8'd0) begin
                  r_state     <= RUN;
                  busy_o      <= 1'b0;
                  cpu_reset_o <= 1'b0;
                  done_o      <= 1'b1;
               end else begin
                  r_delay <= r_delay - 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed scenarios with literal expectations
// plus randomized loads, all checked every cycle against a behavioural model.
module tb_program_loader;

   localparam int          HW    = 16;
   localparam int          WD    = 32;
   localparam int          DEPTH = 256;
   localparam int          DELAY = 4;
   localparam logic [31:0] BASE  = 32'h0;

   logic        clk        = 1'b0;
   logic        resetN     = 1'b0;
   logic        start      = 1'b0;
   logic [15:0] progLen    = '0;
   logic        dataValid  = 1'b0;
   logic [15:0] dataIn     = '0;
   logic        dataReady;
   logic        memWe;
   logic [15:0] instr;
   logic [31:0] instrAddr;
   logic        cpuReset;
   logic        busy;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;
   bit cmpEn  = 1'b0;

   int          cyc = 0;
   int          fallCyc = -1;
   logic        prevCpuReset = 1'b1;
   logic [31:0] logAddr[$];
   logic [15:0] logData[$];
   int          logCyc[$];
   logic [15:0] progData [0:299];

   typedef struct {
      bit          loading;
      bit          releasing;
      bit          running;
      bit          err;
      bit          write;
      int          beats;
      int          len;
      int          relLeft;
      logic [15:0] wData;
      logic [31:0] wAddr;
   } model_t;

   model_t m;

   program_loader #(
      .HALF_WORD(HW), .WORD(WD), .PROG_DEPTH(DEPTH),
      .BASE_ADDR(BASE), .RELEASE_DELAY(DELAY)
   ) dut (
      .clk_i(clk), .reset_n_i(resetN), .start_i(start), .prog_len_i(progLen),
      .data_valid_i(dataValid), .data_i(dataIn), .data_ready_o(dataReady),
      .program_mem_write_en_o(memWe), .instruction_o(instr),
      .instruction_addr_o(instrAddr), .cpu_reset_o(cpuReset),
      .busy_o(busy), .done_o(done), .error_o(error)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Model step: what one rising edge does to the loader's abstract situation.
   function automatic model_t modelStep(model_t cur, bit s, int len, bit v, logic [15:0] d);
      model_t n = cur;
      n.write = 1'b0;
      if (cur.loading) begin
         if (v && cur.beats < cur.len) begin
            n.write = 1'b1;
            n.wData = d;
            n.wAddr = BASE + 32'(2 * cur.beats);
            n.beats = cur.beats + 1;
            if (n.beats == cur.len) begin
               n.loading   = 1'b0;
               n.releasing = 1'b1;
               n.relLeft   = DELAY;
            end
         end
      end else if (cur.releasing) begin
         n.relLeft = cur.relLeft - 1;
         if (n.relLeft == 0) begin
            n.releasing = 1'b0;
            n.running   = 1'b1;
         end
      end else if (s) begin
         if (len >= 1 && len <= DEPTH) begin
            n.loading = 1'b1;
            n.beats   = 0;
            n.len     = len;
            n.err     = 1'b0;
            n.running = 1'b0;
         end else begin
            n.err     = 1'b1;
            n.running = 1'b0;
         end
      end
      return n;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [15:0] len, input logic v, input logic [15:0] d);
      start     = s;
      progLen   = len;
      dataValid = v;
      dataIn    = d;
      @(negedge clk);
   endtask

   // Advance the model on every edge; reset clears it at once.
   always @(posedge clk or negedge resetN) begin
      if (!resetN) m <= '{default: 0};
      else         m <= modelStep(m, start, int'(progLen), dataValid, dataIn);
   end

   // Compare every output against the model in the middle of each cycle.
   always @(negedge clk) begin
      if (cmpEn) begin
         checkOutput("ready",    32'(dataReady), 32'(m.loading && (m.beats < m.len)));
         checkOutput("writeEn",  32'(memWe),     32'(m.write));
         checkOutput("cpuReset", 32'(cpuReset),  32'(!m.running));
         checkOutput("busy",     32'(busy),      32'(m.loading || m.releasing));
         checkOutput("done",     32'(done),      32'(m.running));
         checkOutput("error",    32'(error),     32'(m.err));
         if (m.write) begin
            checkOutput("instr", 32'(instr), 32'(m.wData));
            checkOutput("addr",  instrAddr,  m.wAddr);
         end
      end
   end

   // Cycle counter and write/release log used by the literal checks.
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (memWe) begin
         logAddr.push_back(instrAddr);
         logData.push_back(instr);
         logCyc.push_back(cyc);
      end
      if (prevCpuReset && !cpuReset) fallCyc <= cyc;
      prevCpuReset <= cpuReset;
   end

   task automatic clearLog();
      logAddr.delete();
      logData.delete();
      logCyc.delete();
      fallCyc = -1;
   endtask

   task automatic waitDone(input bit poke);
      int n = 0;
      while (!done && n < 60) begin
         if (poke && busy && $urandom_range(0, 2) == 0)
            applyStimulus(1'b1, 16'($urandom_range(0, 300)), 1'b0, 16'h0);
         else
            applyStimulus(1'b0, 16'h0, 1'($urandom_range(0, 1)), 16'($urandom));
         n++;
      end
      checkOutput("doneTimeout", 32'(done), 32'd1);
   endtask

   // Start a load and feed progData; pattern 0 = always valid,
   // 1 = valid every other cycle, 2 = random valid.
   task automatic feedProgram(input int len, input int pattern, input bit poke);
      int   idx = 0;
      int   budget = 0;
      logic v;
      logic s;
      logic acc;
      applyStimulus(1'b1, 16'(len), 1'b0, 16'h0);
      if (len >= 1 && len <= DEPTH) begin
         while (idx < len && budget < 400) begin
            case (pattern)
               0:       v = 1'b1;
               1:       v = (budget % 2 == 0);
               default: v = ($urandom_range(0, 3) != 0);
            endcase
            s   = poke && ($urandom_range(0, 3) == 0);
            acc = v && dataReady;
            applyStimulus(s, 16'($urandom_range(0, 300)), v, progData[idx]);
            if (acc) idx++;
            budget++;
         end
         checkOutput("loadTimeout", 32'(idx), 32'(len));
         waitDone(poke);
      end else begin
         applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
      end
   endtask

   task automatic checkLoadLog(input int n, input bit consecutive, input int relGap);
      #1;
      checkOutput("logCount", 32'(logAddr.size()), 32'(n));
      for (int i = 0; i < n && i < logAddr.size(); i++) begin
         checkOutput("logAddr", logAddr[i], BASE + 32'(2 * i));
         checkOutput("logData", 32'(logData[i]), 32'(progData[i]));
         if (consecutive && i > 0)
            checkOutput("logBackToBack", 32'(logCyc[i] - logCyc[i-1]), 32'd1);
      end
      if (logAddr.size() == n && n > 0)
         checkOutput("releaseGap", 32'(fallCyc - logCyc[n-1]), 32'(relGap));
   endtask

   initial begin
      int len;
      int r;

      // Reset state.
      resetN = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rstCpuReset", 32'(cpuReset), 32'd1);
      checkOutput("rstReady",    32'(dataReady), 32'd0);
      checkOutput("rstWe",       32'(memWe), 32'd0);
      checkOutput("rstBusy",     32'(busy), 32'd0);
      checkOutput("rstDone",     32'(done), 32'd0);
      checkOutput("rstInstr",    32'(instr), 32'd0);
      checkOutput("rstAddr",     instrAddr, 32'd0);
      cmpEn  = 1'b1;
      resetN = 1'b1;
      repeat (2) applyStimulus(1'b0, 16'h0, 1'b1, 16'h1111);
      checkOutput("idleHold", 32'(busy), 32'd0);

      // Three back-to-back beats, release four cycles after the last write.
      $display("[TB] directed: three-beat load");
      clearLog();
      progData[0] = 16'hA001; progData[1] = 16'hA002; progData[2] = 16'hA003;
      feedProgram(3, 0, 1'b0);
      checkLoadLog(3, 1'b1, 4);
      checkOutput("doneAfterLoad", 32'(done), 32'd1);
      checkOutput("cpuRunning",    32'(cpuReset), 32'd0);

      // Source stalls every other cycle.
      $display("[TB] directed: stalled source");
      clearLog();
      for (int i = 0; i < 4; i++) progData[i] = 16'hB000 + 16'(i);
      feedProgram(4, 1, 1'b0);
      checkLoadLog(4, 1'b0, 4);

      // Start requests during LOAD and DRAIN are ignored.
      $display("[TB] directed: start ignored while busy");
      clearLog();
      for (int i = 0; i < 3; i++) progData[i] = 16'hC000 + 16'(i);
      feedProgram(3, 0, 1'b1);
      checkLoadLog(3, 1'b1, 4);

      // Rejected lengths, then a valid start clears the error.
      $display("[TB] directed: length errors");
      clearLog();
      applyStimulus(1'b1, 16'd0, 1'b0, 16'h0);
      checkOutput("errLen0",      32'(error), 32'd1);
      checkOutput("errLen0Reset", 32'(cpuReset), 32'd1);
      checkOutput("errLen0Done",  32'(done), 32'd0);
      applyStimulus(1'b1, 16'd257, 1'b0, 16'h0);
      checkOutput("errLen257",     32'(error), 32'd1);
      checkOutput("errLen257Busy", 32'(busy), 32'd0);
      applyStimulus(1'b0, 16'd0, 1'b1, 16'h0);
      #1 checkOutput("errNoStrobe", 32'(logAddr.size()), 32'd0);
      progData[0] = 16'hBEEF;
      applyStimulus(1'b1, 16'd1, 1'b0, 16'h0);
      checkOutput("errCleared", 32'(error), 32'd0);
      checkOutput("errBusy",    32'(busy), 32'd1);
      applyStimulus(1'b0, 16'd0, 1'b1, 16'hBEEF);
      waitDone(1'b0);
      checkLoadLog(1, 1'b0, 4);

      // Reload from RUN.
      $display("[TB] directed: reload from run");
      clearLog();
      progData[0] = 16'hD000; progData[1] = 16'hD001;
      applyStimulus(1'b1, 16'd2, 1'b0, 16'h0);
      checkOutput("reloadCpuReset", 32'(cpuReset), 32'd1);
      checkOutput("reloadDone",     32'(done), 32'd0);
      applyStimulus(1'b0, 16'd0, 1'b1, 16'hD000);
      applyStimulus(1'b0, 16'd0, 1'b1, 16'hD001);
      waitDone(1'b0);
      checkLoadLog(2, 1'b1, 4);

      // Reset in the middle of a five-beat load.
      $display("[TB] directed: reset mid-load");
      clearLog();
      applyStimulus(1'b1, 16'd5, 1'b0, 16'h0);
      applyStimulus(1'b0, 16'd0, 1'b1, 16'h5000);
      applyStimulus(1'b0, 16'd0, 1'b1, 16'h5001);
      dataValid = 1'b1;
      dataIn    = 16'h5002;
      #2 resetN = 1'b0;
      #1;
      checkOutput("midRstReady",    32'(dataReady), 32'd0);
      checkOutput("midRstWe",       32'(memWe), 32'd0);
      checkOutput("midRstBusy",     32'(busy), 32'd0);
      checkOutput("midRstCpuReset", 32'(cpuReset), 32'd1);
      checkOutput("midRstInstr",    32'(instr), 32'd0);
      checkOutput("midRstAddr",     instrAddr, 32'd0);
      checkOutput("midRstWrites",   32'(logAddr.size()), 32'd2);
      @(negedge clk);
      resetN = 1'b1;
      repeat (4) applyStimulus(1'b0, 16'd0, 1'b1, 16'h5003);
      #1 checkOutput("noWriteAfterReset", 32'(logAddr.size()), 32'd2);
      checkOutput("idleAfterReset", 32'(busy), 32'd0);

      // Randomized loads, including rejected lengths and ignored starts.
      $display("[TB] random loads");
      for (int t = 0; t < 30; t++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      len = 0;
         else if (r == 1) len = 257 + $urandom_range(0, 100);
         else             len = $urandom_range(1, 12);
         for (int i = 0; i < 16; i++) progData[i] = 16'($urandom);
         feedProgram(len, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      repeat (2) applyStimulus(1'b0, 16'd0, 1'b0, 16'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
